lux_bcd_display: RTL and testbench

- Sits between the lux/FSM data path and the seven_seg driver.
- Accepts an 8-bit binary lux reading over a valid/ready handshake and converts it to three BCD digits with an iterative double-dabble engine.
- Holds the result and time-multiplexes the digits as display_value/display_select at a programmable refresh rate.
- Gives seven_seg a stable, tear-free decimal source.

---
 rtl/lux_bcd_display.sv | 164 ++++++++++++++++
 tb/tb_lux_bcd_display.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lux_bcd_display.sv
// Binary-to-BCD converter (iterative double-dabble) with a time-multiplexed digit scanner for seven_seg.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits on the display only.
module lux_bcd_display #(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [3:0]  display_value,
    output logic [1:0]  display_select
);

    localparam int unsigned      PRE_W    = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [19:0]      shift_r;
    logic [19:0]      corr_s;
    logic [2:0]       cnt_r;
    logic [11:0]      bcd_r;
    logic             bcd_valid_r;
    logic [PRE_W-1:0] pre_r;
    logic [1:0]       sel_r;
    logic [3:0]       value_s;
    logic             hund_blank_s;
    logic             tens_blank_s;
    logic             accept_s;

    function automatic logic [3:0] add3(input logic [3:0] d);
        if (d >= 4'd5) begin
            add3 = d + 4'd3;
        end else begin
            add3 = d;
        end
    endfunction

    assign in_ready = (state_r == IDLE) && !rst;
    assign busy     = (state_r != IDLE);
    assign accept_s = in_valid && in_ready;

    // Next-state logic of the conversion sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == 3'd7) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Add-3 correction applied to each BCD nibble before the shift.
    always_comb begin
        corr_s = {add3(shift_r[19:16]), add3(shift_r[15:12]), add3(shift_r[11:8]), shift_r[7:0]};
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Conversion datapath; bcd only changes on the DONE edge so no partial result is ever visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r     <= 20'h00000;
            cnt_r       <= 3'd0;
            bcd_r       <= 12'h000;
            bcd_valid_r <= 1'b0;
        end else begin
            bcd_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r <= {12'h000, in_data};
                        cnt_r   <= 3'd0;
                    end
                end
                SHIFT: begin
                    // Hundreds never exceeds 2, so the bit shifted out of the top is always zero.
                    shift_r <= 20'({corr_s, 1'b0});
                    cnt_r   <= cnt_r + 3'd1;
                end
                DONE: begin
                    bcd_r       <= shift_r[19:8];
                    bcd_valid_r <= 1'b1;
                end
                default: begin
                    shift_r <= 20'h00000;
                end
            endcase
        end
    end

    // Free-running refresh prescaler and digit selector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
            sel_r <= 2'd0;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= '0;
            sel_r <= sel_r + 2'd1;
        end else begin
            pre_r <= pre_r + PRE_W'(1'b1);
        end
    end

    // Leading-zero suppression flags for the upper two digit slots.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        hund_blank_s = (bcd_r[11:8] == 4'd0);
        tens_blank_s = (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0);
`else
        hund_blank_s = 1'b0;
        tens_blank_s = 1'b0;
`endif
    end

    // Digit mux; reads the bcd register directly so an update shows in the same cycle.
    always_comb begin
        value_s = BLANK_CODE;
        case (sel_r)
            2'd0:    value_s = bcd_r[3:0];
            2'd1:    value_s = tens_blank_s ? BLANK_CODE : bcd_r[7:4];
            2'd2:    value_s = hund_blank_s ? BLANK_CODE : bcd_r[11:8];
            2'd3:    value_s = BLANK_CODE;
            default: value_s = BLANK_CODE;
        endcase
    end

    assign bcd            = bcd_r;
    assign bcd_valid      = bcd_valid_r;
    assign display_value  = value_s;
    assign display_select = sel_r;

endmodule

// File: tb/tb_lux_bcd_display.sv
// Scoreboard bench for lux_bcd_display: driver pushes expected BCD at each handshake, monitor checks every cycle.
module tb_lux_bcd_display;

    localparam int         DIV   = 4;
    localparam logic [3:0] BLANK = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_LEAD = 1'b1;
`else
    localparam bit BLANK_LEAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        busy;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [3:0]  display_value;
    logic [1:0]  display_select;

    lux_bcd_display #(.REFRESH_DIV(DIV), .BLANK_CODE(BLANK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .bcd(bcd), .bcd_valid(bcd_valid),
        .display_value(display_value), .display_select(display_select)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] bcd;
        logic [31:0] e0;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        popped;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          since_rst = 0;
    bit          rst_at_edge = 1'b0;
    bit          started = 1'b0;
    logic [11:0] ref_bcd = 12'h000;
    int          busy_from = 0;
    int          busy_to = -1;
    bit          prev_valid = 1'b0;
    bit          exp_busy;
    int          sel_exp;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] slot(input logic [11:0] b, input int s);
        int h = int'(b[11:8]);
        int t = int'(b[7:4]);
        int o = int'(b[3:0]);
        case (s)
            0:       return 4'(o);
            1:       return (BLANK_LEAD && h == 0 && t == 0) ? BLANK : 4'(t);
            2:       return (BLANK_LEAD && h == 0) ? BLANK : 4'(h);
            default: return BLANK;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counters of the reference model: time since start and since the last reset edge.
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
        if (rst) begin
            since_rst <= 0;
            started   <= 1'b1;
        end else begin
            since_rst <= since_rst + 1;
        end
    end

    // Monitor: pops the scoreboard on bcd_valid and checks every output each cycle.
    always @(negedge clk) begin
        if (started) begin
            if (rst_at_edge) begin
                exp_q.delete();
                ref_bcd = 12'h000;
                busy_to = -1;
            end
            if (bcd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bcd_valid", 1, 0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("bcd_valid_latency", cyc - int'(popped.e0), 9);
                    ref_bcd = popped.bcd;
                end
            end else if (exp_q.size() > 0 && cyc > int'(exp_q[0].e0) + 9) begin
                chk("missing_bcd_valid", 0, 1);
                popped = exp_q.pop_front();
                ref_bcd = popped.bcd;
            end
            chk("bcd_valid_double", int'(prev_valid && bcd_valid), 0);
            prev_valid = bcd_valid;
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            sel_exp  = (since_rst / DIV) % 4;
            chk("busy", int'(busy), int'(exp_busy));
            chk("in_ready", int'(in_ready), int'(!rst && !exp_busy));
            chk("bcd", int'(bcd), int'(ref_bcd));
            chk("display_select", int'(display_select), sel_exp);
            chk("display_value", int'(display_value), int'(slot(ref_bcd, sel_exp)));
        end
    end

    task automatic push_exp(input logic [7:0] v);
        exp_q.push_back({to_bcd(int'(v)), 32'(cyc + 1)});
        busy_from = cyc + 1;
        busy_to   = cyc + 9;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_conv(input logic [7:0] v, input int gap);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(v);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!done) chk("handshake_timeout", 0, 1);
        idle(gap);
    endtask

    task automatic back_pressure();
        int last = -1;
        in_valid = 1'b1;
        for (int i = 0; i < 85; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            if (in_ready) begin
                push_exp(in_data);
                if (last >= 0) chk("accept_spacing", cyc + 1 - last, 10);
                last = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(12);
    endtask

    int dir[9] = '{0, 9, 10, 99, 100, 255, 7, 40, 105};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd55;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(2);

        foreach (dir[i]) do_conv(8'(dir[i]), 20);
        for (int v = 0; v < 256; v++) do_conv(8'(v), int'($urandom_range(0, 2)));

        back_pressure();

        do_conv(8'd200, 0);
        idle(3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        do_conv(8'd37, 20);

        idle(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
